// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter between core writeback and AHB returns
module rf_wb_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [ADDR_W-1:0]            head_addr,
    output logic [DATA_W-1:0]            head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [DEPTH-1:0]             slot_valid,
    output logic [DEPTH*ADDR_W-1:0]      slot_addr
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Per-slot valid bits let the hazard check scan entries without pointer math.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            slot_valid <= '0;
        end else begin
            if (push) begin
                addr_mem[wr_ptr]   <= push_addr;
                data_mem[wr_ptr]   <= push_data;
                slot_valid[wr_ptr] <= 1'b1;
                wr_ptr             <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                slot_valid[rd_ptr] <= 1'b0;
                rd_ptr             <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign slot_addr[i*ADDR_W +: ADDR_W] = addr_mem[i];
    end
endmodule

module rf_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_STREAK = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                core_we,
    input  logic [ADDR_W-1:0]                   core_addr,
    input  logic [DATA_W-1:0]                   core_wdata,
    output logic                                core_ready,
    input  logic                                ahb_valid,
    input  logic [ADDR_W-1:0]                   ahb_addr,
    input  logic [DATA_W-1:0]                   ahb_rdata,
    output logic                                ahb_ready,
    input  logic [ADDR_W-1:0]                   rs1_addr,
    input  logic [ADDR_W-1:0]                   rs2_addr,
    output logic                                hazard,
    output logic                                rf_we,
    output logic [ADDR_W-1:0]                   rf_addr,
    output logic [DATA_W-1:0]                   rf_wdata,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int STREAK_W = $clog2(MAX_STREAK + 1);

    logic                         push;
    logic                         pop;
    logic                         head_valid;
    logic                         core_cand;
    logic                         grant_ahb;
    logic                         grant_core;
    logic [STREAK_W-1:0]          streak;
    logic [STREAK_W-1:0]          streak_nxt;
    logic [ADDR_W-1:0]            head_addr;
    logic [DATA_W-1:0]            head_data;
    logic [FIFO_DEPTH-1:0]        slot_valid;
    logic [FIFO_DEPTH*ADDR_W-1:0] slot_addr;
    logic                         haz1;
    logic                         haz2;

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
    assign ahb_ready  = !rst && (fifo_count != CNT_W'(FIFO_DEPTH));
    assign push       = ahb_valid && ahb_ready && (ahb_addr != '0);
    assign head_valid = (fifo_count != '0);
    assign core_cand  = core_we && (core_addr != '0);
    assign pop        = grant_ahb;

    rf_wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_addr  (ahb_addr),
        .push_data  (ahb_rdata),
        .pop        (pop),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (fifo_count),
        .slot_valid (slot_valid),
        .slot_addr  (slot_addr)
    );

    always_comb begin
        grant_ahb  = 1'b0;
        grant_core = 1'b0;
        core_ready = 1'b0;
        streak_nxt = streak;
        if (!rst) begin
            if (core_we && (core_addr == '0)) begin
                core_ready = 1'b1;
            end
            if (head_valid && core_cand) begin
                if (head_addr == core_addr) begin
                    // Older AHB data wins; the core write is acked but dropped.
                    grant_ahb  = 1'b1;
                    core_ready = 1'b1;
                    streak_nxt = '0;
                end else if (streak < STREAK_W'(MAX_STREAK)) begin
                    grant_ahb  = 1'b1;
                    streak_nxt = streak + 1'b1;
                end else begin
                    grant_core = 1'b1;
                    core_ready = 1'b1;
                    streak_nxt = '0;
                end
            end else if (head_valid) begin
                grant_ahb = 1'b1;
                if (!core_we) streak_nxt = '0;
            end else if (core_cand) begin
                grant_core = 1'b1;
                core_ready = 1'b1;
                streak_nxt = '0;
            end else if (!core_we) begin
                streak_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak   <= '0;
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
        end else begin
            streak <= streak_nxt;
            rf_we  <= grant_ahb || grant_core;
            if (grant_ahb) begin
                rf_addr  <= head_addr;
                rf_wdata <= head_data;
            end else if (grant_core) begin
                rf_addr  <= core_addr;
                rf_wdata <= core_wdata;
            end
        end
    end

    always_comb begin
        haz1 = rf_we && (rf_addr == rs1_addr);
        haz2 = rf_we && (rf_addr == rs2_addr);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (slot_valid[i] && (slot_addr[i*ADDR_W +: ADDR_W] == rs1_addr)) haz1 = 1'b1;
            if (slot_valid[i] && (slot_addr[i*ADDR_W +: ADDR_W] == rs2_addr)) haz2 = 1'b1;
        end
    end

    assign hazard = ((rs1_addr != '0) && haz1) || ((rs2_addr != '0) && haz2);
endmodule
